// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample/address widths,
// buffer FSM states and the bit-reverse helper used by FFT stages.
package fft_pkg;

    localparam int WORDSIZE_DEF = 16;
    localparam int ADDRSIZE_DEF = 5;

    typedef enum logic {
        FILL,
        DRAIN
    } buf_state_e;

    // Reverse the low w bits of a (w <= 16); upper result bits are zero.
    function automatic logic [15:0] bitrev(input logic [15:0] a, input int w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = a[15-i];
        end
        return r >> (16 - w);
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM with chip select.
// Read data appears one cycle after a read is issued.
module ram #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 5,
    parameter int NUMADDR  = 32
) (
    input  logic                clk,
    input  logic                cs,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDRSIZE-1:0] addr,
    input  logic [WORDSIZE-1:0] wdata,
    output logic [WORDSIZE-1:0] rdata
);

    logic [WORDSIZE-1:0] mem [NUMADDR];

    always_ff @(posedge clk) begin
        if (cs && wr_en) begin
            mem[addr] <= wdata;
        end
        if (cs && rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bitrev_buf.sv
// Frame buffer: fills N samples in natural order, then drains them
// in bit-reversed address order through a 2-entry output FIFO.
module bitrev_buf
    import fft_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int N = 2 ** ADDRSIZE;

    buf_state_e          state, state_nx;
    logic [ADDRSIZE-1:0] wr_cnt;
    logic [ADDRSIZE:0]   rd_cnt;
    logic                rd_vld, rd_last;
    logic [1:0]          cnt;
    logic [WORDSIZE-1:0] d0, d1;
    logic                l0, l1;

    logic                wr_en, rd_issue;
    logic                in_xfer, out_xfer;
    logic [1:0]          occ, wpos;
    logic                space;
    logic [ADDRSIZE-1:0] rev_addr, ram_addr;
    logic [WORDSIZE-1:0] rdata;

    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = d0;
    assign out_last  = out_valid && l0;

    // Entries held plus the read in flight must fit after this cycle's pop.
    assign occ   = cnt + {1'b0, rd_vld};
    assign space = (occ - {1'b0, out_xfer}) < 2'd2;
    assign wpos  = cnt - {1'b0, out_xfer};

    assign rev_addr = ADDRSIZE'(bitrev(16'(rd_cnt[ADDRSIZE-1:0]), ADDRSIZE));
    assign ram_addr = (state == FILL) ? wr_cnt : rev_addr;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        rd_issue = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (in_valid && (&wr_cnt)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                rd_issue = !rd_cnt[ADDRSIZE] && space;
                if (out_xfer && l0) begin
                    state_nx = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_vld  <= rd_issue;
            rd_last <= rd_issue && (&rd_cnt[ADDRSIZE-1:0]);
            if (in_xfer) begin
                wr_cnt <= wr_cnt + {{(ADDRSIZE-1){1'b0}}, 1'b1};
            end
            if (state == DRAIN && state_nx == FILL) begin
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + {{ADDRSIZE{1'b0}}, 1'b1};
            end
        end
    end

    // Pop shifts the tail forward; a push then lands behind what remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
        end else begin
            cnt <= cnt + {1'b0, rd_vld} - {1'b0, out_xfer};
            if (out_xfer) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (rd_vld) begin
                if (wpos == 2'd0) begin
                    d0 <= rdata;
                    l0 <= rd_last;
                end else begin
                    d1 <= rdata;
                    l1 <= rd_last;
                end
            end
        end
    end

    ram #(
        .WORDSIZE(WORDSIZE),
        .ADDRSIZE(ADDRSIZE),
        .NUMADDR (N)
    ) u_ram (
        .clk  (clk),
        .cs   (wr_en || rd_issue),
        .wr_en(wr_en),
        .rd_en(rd_issue),
        .addr (ram_addr),
        .wdata(in_data),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_bitrev_buf.sv
// Randomized bench for bitrev_buf against a frame-level model:
// stored frame array read back through arithmetic bit reversal.
module tb_bitrev_buf;

    localparam int W = 16;
    localparam int A = 5;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;

    bitrev_buf #(.WORDSIZE(W), .ADDRSIZE(A)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < A; i++) begin
            r = (r * 2) + ((k / (2 ** i)) % 2);
        end
        return r;
    endfunction

    // stimulus knobs
    bit en_in = 1'b0;
    bit gap = 1'b0;
    bit rdy_rand = 1'b0;
    int next_word = 0;

    // model state
    bit           m_fill = 1'b1;
    int           m_wcnt = 0;
    int           m_ocnt = 0;
    int           m_d = 0;
    bit           m_full_rdy = 1'b0;
    int           frames_done = 0;
    logic [W-1:0] m_mem [N];
    logic [W-1:0] log_q [8][N];
    bit           stall = 1'b0;
    logic [W-1:0] stall_data = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            in_valid = en_in && (!gap || $urandom_range(1, 0) == 1);
            in_data = W'(next_word);
            out_ready = !rdy_rand || ($urandom_range(1, 0) == 1);
            @(negedge clk);
            if (!rst && in_valid && in_ready) next_word++;
        end
    end

    always @(negedge clk) begin
        bit fill_now;
        if (rst) begin
            m_fill = 1'b1;
            m_wcnt = 0;
            m_ocnt = 0;
            stall = 1'b0;
        end else begin
            fill_now = m_fill;
            chk("in_ready", in_ready, fill_now);
            if (!fill_now) begin
                if (m_full_rdy) chk("drain_valid_timing", out_valid, m_d >= 2);
                m_d++;
                if (!out_ready) m_full_rdy = 1'b0;
            end else begin
                chk("valid_in_fill", out_valid, 0);
            end
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_data);
            end
            if (out_valid) begin
                chk("out_data", out_data, m_mem[brev(m_ocnt)]);
                chk("out_last", out_last, m_ocnt == N - 1);
                stall = !out_ready;
                stall_data = out_data;
                if (out_ready) begin
                    log_q[frames_done % 8][m_ocnt] = out_data;
                    m_ocnt++;
                    if (m_ocnt == N) begin
                        m_fill = 1'b1;
                        m_ocnt = 0;
                        frames_done++;
                    end
                end
            end else begin
                chk("out_last_idle", out_last, 0);
                stall = 1'b0;
            end
            if (fill_now && in_valid) begin
                m_mem[m_wcnt] = in_data;
                m_wcnt++;
                if (m_wcnt == N) begin
                    m_fill = 1'b0;
                    m_wcnt = 0;
                    m_d = 0;
                    m_full_rdy = 1'b1;
                end
            end
        end
    end

    task automatic wait_frames(input int target);
        int c = 0;
        while (frames_done < target && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk("frame_timeout", frames_done >= target, 1);
    endtask

    initial begin
        int c;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        en_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // two back-to-back frames, in_valid high throughout
        wait_frames(2);
        chk("f0_idx0", log_q[0][0], 0);
        chk("f0_idx1", log_q[0][1], 16);
        chk("f0_idx2", log_q[0][2], 8);
        chk("f0_idx3", log_q[0][3], 24);
        chk("f0_idx4", log_q[0][4], 4);
        chk("f0_idx5", log_q[0][5], 20);
        chk("f0_idx31", log_q[0][31], 31);
        chk("f1_idx1", log_q[1][1], 48);

        rdy_rand = 1'b1;
        wait_frames(3);
        gap = 1'b1;
        wait_frames(4);

        // reset mid-drain after 10 outputs
        gap = 1'b0;
        c = 0;
        while (!(!m_fill && m_ocnt >= 10) && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk("reach_10_outputs", m_ocnt >= 10, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        next_word = 100;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_last", out_last, 0);
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_frames(5);
        chk("post_rst_idx0", log_q[4][0], 100);
        chk("post_rst_idx1", log_q[4][1], 116);
        chk("post_rst_idx31", log_q[4][31], 131);

        en_in = 1'b0;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitrev_buf.md
BITREV_BUF -- requirements
Module: bitrev_buf

Interface
REQ-001 Parameter WORDSIZE, default 16: sample width in bits (Q5.10 fixed point, not interpreted by this block).
REQ-002 Parameter ADDRSIZE, default 5: address width; frame length N = 2**ADDRSIZE.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_data, input, WORDSIZE: sample to store.
REQ-006 Port in_valid, input, 1: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 Port out_data, output, WORDSIZE: sample read back in bit-reversed order.
REQ-009 Port out_valid, output, 1: out_data is valid.
REQ-010 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-011 Port out_last, output, 1: out_data is the final (Nth) sample of the frame; qualified by out_valid.

Function
REQ-012 States: FILL (accept N writes) and DRAIN (emit N reads); state is decided by a registered FSM.
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 FILL: in_ready = 1; each input transfer writes in_data to RAM address wr_cnt; wr_cnt then increments.
REQ-015 FILL -> DRAIN on the input transfer with wr_cnt = N-1; wr_cnt wraps to 0 on that same edge.
REQ-016 DRAIN: in_ready = 0; input transfers are impossible; in_valid is ignored.
REQ-017 DRAIN read address = bit-reverse of rd_cnt over ADDRSIZE bits; rd_cnt increments per read issued, 0..N-1.
REQ-018 RAM read latency is exactly 1 cycle; read data lands in a 2-entry output FIFO that drives out_data/out_valid.
REQ-019 A read is issued only if the FIFO has space for it, counting reads in flight; no read data is ever dropped.
REQ-020 With out_ready held high, the block sustains one output per cycle after a 2-cycle startup from DRAIN entry.
REQ-021 out_ready low holds out_data and out_valid stable until the transfer occurs.
REQ-022 out_last = 1 exactly on the word read from bit-reversed address of rd_cnt = N-1.
REQ-023 DRAIN -> FILL on the output transfer with out_last = 1; in_ready rises in the following cycle.
REQ-024 The first sample of the next frame cannot be accepted in the same cycle as the final output transfer.
REQ-025 in_valid gaps in FILL stall wr_cnt; there is no timeout.
REQ-026 Simultaneous read and write never occur: FILL never reads and DRAIN never writes.

Reset
REQ-027 Asserting rst forces the following immediately, regardless of clk: FSM = FILL, wr_cnt = 0, rd_cnt = 0, FIFO empty, in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
REQ-028 Reset mid-frame discards the partial frame; RAM contents are not cleared and are not relied upon.
REQ-029 The first input transfer is permitted on the first rising clk edge after rst deasserts.

Structure
REQ-030 WORDSIZE/ADDRSIZE defaults and a bit-reverse function belong in the shared FFT package, reused by the FFT stages.
REQ-031 Storage shall be one instance of the existing ram sub-module with NUMADDR = N; the FSM drives its rd_en, wr_en and cs.
REQ-032 The 2-entry output FIFO is implemented inline; no further sub-modules.

Verification
REQ-033 Stimulus: write 0..31, out_ready = 1. Required response: outputs in order 0,16,8,24,4,20,...,31, with out_last only on 31.
REQ-034 Stimulus: out_ready toggles 1,0,0,1 pseudo-randomly during DRAIN. Required response: the same 32-word sequence, no loss or duplication, and data stable while stalled.
REQ-035 Stimulus: in_valid with 50% gaps during FILL. Required response: exactly 32 accepted; DRAIN starts only after the 32nd acceptance.
REQ-036 Stimulus: in_valid held high through DRAIN. Required response: in_ready = 0, and the next frame's first word is accepted only in the cycle after out_last transfers.
REQ-037 Stimulus: assert rst after 10 outputs of a frame. Required response: out_valid = 0 immediately and in_ready = 1; a fresh frame of 100..131 then drains correctly in bit-reversed order.
REQ-038 Stimulus: two back-to-back frames with out_ready = 1. Required response: 32 outputs per frame, with exactly one out_last per frame.
